radar_pulse_sequencer: RTL

Scheduler in front of `radar_pulse_controller` that steps through a table of up to NUM_PROFILES pulse profiles. Each profile is a PRF integer count, a PRF fractional count and an ADC sample count. For each profile the block rewrites the controller's setting registers over a settings bus and lets a programmed number of pulses run. It counts completed pulses on the controller's `adc_last`, then advances to the next profile. It sits between the host settings bus and the pulse controller, and gates the controller's `awg_ready` so a new chirp cannot start while a profile is loading.

---
 rtl/radar_seq_pkg.sv | 38 +++
 rtl/radar_pulse_sequencer_if.sv | 29 ++
 rtl/radar_seq_profile_table.sv | 41 ++++
 rtl/radar_pulse_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/radar_seq_pkg.sv
// rtl/radar_seq_pkg.sv - shared encodings and constants for the radar pulse sequencer
package radar_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_t;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_ABORT_BIT = 1;
   localparam int CTRL_LOOP_BIT  = 2;
   localparam int CTRL_LAST_LSB  = 8;

   localparam logic [1:0] FIELD_INT  = 2'd0;
   localparam logic [1:0] FIELD_FRAC = 2'd1;
   localparam logic [1:0] FIELD_ADC  = 2'd2;
   localparam logic [1:0] FIELD_RSVD = 2'd3;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PULSES = 2'd1;
   localparam logic [1:0] REG_TSEL   = 2'd2;
   localparam logic [1:0] REG_TDATA  = 2'd3;

   localparam logic [31:0] TBL_RST_INT  = 32'h0000_0000;
   localparam logic [31:0] TBL_RST_FRAC = 32'h1d4c_0000;
   localparam logic [31:0] TBL_RST_ADC  = 32'h0000_01fe;

   function automatic logic [31:0] tbl_rst_value(input logic [1:0] field);
      case (field)
         FIELD_FRAC: return TBL_RST_FRAC;
         FIELD_ADC:  return TBL_RST_ADC;
         default:    return TBL_RST_INT;
      endcase
   endfunction

endpackage

// File: rtl/radar_pulse_sequencer_if.sv
// rtl/radar_pulse_sequencer_if.sv - host settings, controller config and pulse status signals
interface radar_pulse_sequencer_if;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic        cfg_stb;
   logic [7:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        adc_last;
   logic        awg_ready;
   logic        awg_ready_gated;
   logic        busy;
   logic [3:0]  profile_idx;
   logic [31:0] pulse_count;
   logic        seq_done;
   logic        wdog_err;

   modport master (
      output set_stb, set_addr, set_data, adc_last, awg_ready,
      input  cfg_stb, cfg_addr, cfg_data, awg_ready_gated, busy,
             profile_idx, pulse_count, seq_done, wdog_err
   );

   modport slave (
      input  set_stb, set_addr, set_data, adc_last, awg_ready,
      output cfg_stb, cfg_addr, cfg_data, awg_ready_gated, busy,
             profile_idx, pulse_count, seq_done, wdog_err
   );
endinterface

// File: rtl/radar_seq_profile_table.sv
// rtl/radar_seq_profile_table.sv - NUM_PROFILES x 3 x 32 profile register file, one write and one read port
module radar_seq_profile_table
   import radar_seq_pkg::*;
#(
   parameter int NUM_PROFILES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_we,
   input  logic [3:0]  i_wprof,
   input  logic [1:0]  i_wfield,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_rprof,
   input  logic [1:0]  i_rfield,
   output logic [31:0] o_rdata
);

   logic [31:0] r_tbl [NUM_PROFILES][3];

   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PROFILES; p++) begin
         for (int f = 0; f < 3; f++) begin
            if (!reset)
               r_tbl[p][f] <= tbl_rst_value(2'(f));
            else if (i_we && (i_wprof == 4'(p)) && (i_wfield == 2'(f)))
               r_tbl[p][f] <= i_wdata;
         end
      end
   end

   always_comb begin
      o_rdata = '0;
      for (int p = 0; p < NUM_PROFILES; p++) begin
         for (int f = 0; f < 3; f++) begin
            if ((i_rprof == 4'(p)) && (i_rfield == 2'(f)))
               o_rdata = r_tbl[p][f];
         end
      end
   end

endmodule

// File: rtl/radar_pulse_sequencer.sv
// rtl/radar_pulse_sequencer.sv - profile-stepping scheduler for radar_pulse_controller
// Optional RUN watchdog built when RADAR_SEQ_WATCHDOG_EN is defined.
module radar_pulse_sequencer
   import radar_seq_pkg::*;
#(
   parameter int          NUM_PROFILES       = 4,
   parameter logic [7:0]  SR_BASE            = 8'd8,
   parameter logic [7:0]  SR_PRF_INT_ADDR    = 8'd0,
   parameter logic [7:0]  SR_PRF_FRAC_ADDR   = 8'd1,
   parameter logic [7:0]  SR_ADC_SAMPLE_ADDR = 8'd2
`ifdef RADAR_SEQ_WATCHDOG_EN
   , parameter logic [31:0] WDOG_CYCLES      = 32'd400000000
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   radar_pulse_sequencer_if.slave bus
);

   localparam logic [4:0] NP       = 5'(NUM_PROFILES);
   localparam logic [3:0] LAST_MAX = 4'(NUM_PROFILES - 1);

   seq_state_t  r_state, w_state_nxt;
   logic [1:0]  r_ld, w_ld_nxt;
   logic [3:0]  r_idx, w_idx_nxt;
   logic [31:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [31:0] r_pulses, r_pulses_act;
   logic        r_loop_act;
   logic [3:0]  r_last_act;
   logic [5:0]  r_tsel;
   logic        r_cfg_stb;
   logic [7:0]  r_cfg_addr;
   logic [31:0] r_cfg_data;
   logic        r_wdog_err;
   logic [7:0]  w_off;
   logic        w_own, w_ctrl_wr, w_start, w_abort, w_accept, w_tbl_we, w_wdog_trip;
   logic [3:0]  w_last_req;
   logic [31:0] w_tbl_rdata;

   assign w_off      = bus.set_addr - SR_BASE;
   assign w_own      = bus.set_stb && (w_off < 8'd4);
   assign w_ctrl_wr  = w_own && (w_off[1:0] == REG_CTRL);
   assign w_start    = w_ctrl_wr && bus.set_data[CTRL_START_BIT];
   assign w_abort    = w_ctrl_wr && bus.set_data[CTRL_ABORT_BIT];
   assign w_accept   = (r_state == ST_IDLE) && w_start && !w_abort;
   assign w_last_req = bus.set_data[CTRL_LAST_LSB +: 4];
   assign w_tbl_we   = w_own && (w_off[1:0] == REG_TDATA) &&
                       ({1'b0, r_tsel[5:2]} < NP) && (r_tsel[1:0] != FIELD_RSVD);
   assign w_cnt_inc  = r_cnt + 32'd1;

   // Read port follows the next-state index/field so cfg_* register in step with LOAD.
   radar_seq_profile_table #(.NUM_PROFILES(NUM_PROFILES)) u_table (
      .clk      (clk),
      .reset    (reset),
      .i_we     (w_tbl_we),
      .i_wprof  (r_tsel[5:2]),
      .i_wfield (r_tsel[1:0]),
      .i_wdata  (bus.set_data),
      .i_rprof  (w_idx_nxt),
      .i_rfield (w_ld_nxt),
      .o_rdata  (w_tbl_rdata)
   );

`ifdef RADAR_SEQ_WATCHDOG_EN
   logic [31:0] r_wdog;

   always_ff @(posedge clk) begin
      if (!reset)
         r_wdog <= '0;
      else if ((w_state_nxt == ST_RUN) && ((r_state != ST_RUN) || bus.adc_last))
         r_wdog <= WDOG_CYCLES;
      else if ((r_state == ST_RUN) && (r_wdog != 32'd0))
         r_wdog <= r_wdog - 32'd1;
   end

   assign w_wdog_trip = (r_state == ST_RUN) && !bus.adc_last && (r_wdog == 32'd1);
`else
   assign w_wdog_trip = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ld_nxt    = r_ld;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      if (w_abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_start) begin
               w_state_nxt = ST_LOAD;
               w_ld_nxt    = 2'd0;
               w_idx_nxt   = 4'd0;
               w_cnt_nxt   = 32'd0;
            end
            ST_LOAD: if (r_ld == 2'd2) w_state_nxt = ST_RUN;
                     else              w_ld_nxt    = r_ld + 2'd1;
            ST_RUN: if (bus.adc_last) begin
               if (w_cnt_inc >= r_pulses_act) begin
                  if (r_idx < r_last_act || r_loop_act) begin
                     w_state_nxt = ST_LOAD;
                     w_ld_nxt    = 2'd0;
                     w_idx_nxt   = (r_idx < r_last_act) ? r_idx + 4'd1 : 4'd0;
                     w_cnt_nxt   = 32'd0;
                  end else begin
                     w_state_nxt = ST_DONE;
                     w_cnt_nxt   = w_cnt_inc;
                  end
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end else if (w_wdog_trip) begin
               w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy            = (r_state != ST_IDLE);
      bus.seq_done        = (r_state == ST_DONE);
      bus.awg_ready_gated = bus.awg_ready && (r_state == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ld         <= '0;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_pulses     <= '0;
         r_pulses_act <= 32'd1;
         r_loop_act   <= 1'b0;
         r_last_act   <= '0;
         r_tsel       <= '0;
         r_wdog_err   <= 1'b0;
         r_cfg_stb    <= 1'b0;
         r_cfg_addr   <= '0;
         r_cfg_data   <= '0;
      end else begin
         r_ld  <= w_ld_nxt;
         r_idx <= w_idx_nxt;
         r_cnt <= w_cnt_nxt;
         if (w_own && (w_off[1:0] == REG_PULSES)) r_pulses <= bus.set_data;
         if (w_own && (w_off[1:0] == REG_TSEL))   r_tsel   <= bus.set_data[5:0];
         if (w_accept) begin
            r_pulses_act <= (r_pulses == 32'd0) ? 32'd1 : r_pulses;
            r_loop_act   <= bus.set_data[CTRL_LOOP_BIT];
            r_last_act   <= ({1'b0, w_last_req} >= NP) ? LAST_MAX : w_last_req;
            r_wdog_err   <= 1'b0;
         end else if (w_wdog_trip && !w_abort) begin
            r_wdog_err   <= 1'b1;
         end
         r_cfg_stb <= (w_state_nxt == ST_LOAD);
         if (w_state_nxt == ST_LOAD) begin
            case (w_ld_nxt)
               2'd0:    r_cfg_addr <= SR_PRF_INT_ADDR;
               2'd1:    r_cfg_addr <= SR_PRF_FRAC_ADDR;
               default: r_cfg_addr <= SR_ADC_SAMPLE_ADDR;
            endcase
            r_cfg_data <= w_tbl_rdata;
         end
      end
   end

   assign bus.cfg_stb     = r_cfg_stb;
   assign bus.cfg_addr    = r_cfg_addr;
   assign bus.cfg_data    = r_cfg_data;
   assign bus.profile_idx = r_idx;
   assign bus.pulse_count = r_cnt;
   assign bus.wdog_err    = r_wdog_err;

endmodule
